// File: rtl/gpioemu_mulpop.sv
// gpioemu_mulpop -- bus-mapped sequential multiplier with optional ones count.
//
// Two N-bit operands (A1, A2) are written over the CPU bus. A start command
// snapshots them, and a shift-add datapath forms the 2N-bit unsigned product
// at one multiplier bit per clock. When GPIOEMU_MULPOP_POPCNT_EN is defined,
// a further 2N cycles count the ones in the product, one bit per clock.
// Each completed operation increments a CNT_W-bit counter shown on gpio_out.
//
// Optional feature macro: GPIOEMU_MULPOP_POPCNT_EN (ones-count state and
// register). With it undefined, the ones-count register reads 0.
//
// Ports
//   clk             system clock
//   n_reset         asynchronous active-low reset
//   saddress        bus address
//   srd / swr       read / write strobes (levels; each rising edge = one access)
//   sdata_in        write data
//   sdata_out       read data, registered, held until the next read
//   gpio_in         peripheral input, captured on a gpio_latch rising edge
//   gpio_latch      capture strobe for gpio_in
//   gpio_out        completed-operation counter, zero-extended
//   gpio_in_s_insp  captured gpio_in (debug)
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for a start command
//   MULT   | shift-add multiply, N cycles
//   POP    | ones count over the product, 2N cycles (feature build only)
//   DONE   | one cycle: bump the op counter, then IDLE (or MULT on a new start)

module gpioemu_mulpop #(
  parameter int unsigned N       = 24,
  parameter int unsigned CNT_W   = 8,
  parameter logic [15:0] ADDR_A1 = 16'h0370,
  parameter logic [15:0] ADDR_A2 = 16'h0378,
  parameter logic [15:0] ADDR_WH = 16'h0388,
  parameter logic [15:0] ADDR_WL = 16'h0390,
  parameter logic [15:0] ADDR_L  = 16'h0398,
  parameter logic [15:0] ADDR_CS = 16'h03A0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned SW = $clog2(PW);
  localparam int unsigned LW = $clog2(PW + 1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
`ifdef GPIOEMU_MULPOP_POPCNT_EN
    S_POP  = 2'd2,
`endif
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Bus strobe edge detection
  logic srd_q, swr_q, latch_q;
  logic rd_edge, wr_edge, rd_en, latch_edge;
  logic start_req;

  // Registers
  logic [N-1:0]     a1_q, a2_q;
  logic [PW-1:0]    a1_sh_q;
  logic [N-1:0]     a2_sh_q;
  logic [PW-1:0]    prod_q;
  logic [SW-1:0]    step_q;
  logic [1:0]       status_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      sdata_out_q;
  logic [31:0]      gpio_in_s_q;
`ifdef GPIOEMU_MULPOP_POPCNT_EN
  logic [LW-1:0]    pop_q;
`endif

  // FSM outputs
  logic load_op, mult_step, pop_step, done_pulse, busy, enter_done, last_step;

  logic [63:0] prod_ext;
  logic [31:0] rd_data;
  logic        unused_sdata;

  assign rd_edge    = srd & ~srd_q;
  assign wr_edge    = swr & ~swr_q;
  // A write rising together with a read wins; the read is dropped.
  assign rd_en      = rd_edge & ~wr_edge;
  assign latch_edge = gpio_latch & ~latch_q;
  assign start_req  = wr_edge && (saddress == ADDR_CS) && sdata_in[0];
  assign last_step  = (step_q == '0);

  // Upper write-data bits beyond the operand width are intentionally ignored.
  assign unused_sdata = ^sdata_in;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_req) state_d = S_MULT;
      end
      S_MULT: begin
        if (last_step) begin
`ifdef GPIOEMU_MULPOP_POPCNT_EN
          state_d = S_POP;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef GPIOEMU_MULPOP_POPCNT_EN
      S_POP: begin
        if (last_step) state_d = S_DONE;
      end
`endif
      // DONE is not busy, so a start arriving here is honoured directly.
      S_DONE: begin
        state_d = start_req ? S_MULT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_op    = 1'b0;
    mult_step  = 1'b0;
    pop_step   = 1'b0;
    done_pulse = 1'b0;
    busy       = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: load_op = start_req;
      S_MULT: begin
        mult_step = 1'b1;
        busy      = 1'b1;
`ifndef GPIOEMU_MULPOP_POPCNT_EN
        enter_done = last_step;
`endif
      end
`ifdef GPIOEMU_MULPOP_POPCNT_EN
      S_POP: begin
        pop_step   = 1'b1;
        busy       = 1'b1;
        enter_done = last_step;
      end
`endif
      S_DONE: begin
        done_pulse = 1'b1;
        load_op    = start_req;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- strobes
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      srd_q   <= 1'b0;
      swr_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      srd_q   <= srd;
      swr_q   <= swr;
      latch_q <= gpio_latch;
    end
  end

  // ---------------------------------------------------------------- operand regs
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_q <= '0;
      a2_q <= '0;
    end else if (wr_edge) begin
      if (saddress == ADDR_A1) a1_q <= sdata_in[N-1:0];
      if (saddress == ADDR_A2) a2_q <= sdata_in[N-1:0];
    end
  end

  // ---------------------------------------------------------------- datapath
  // The multiplicand shifts left and the multiplier shifts right, so step i
  // always tests a2_sh_q[0] and adds a1 << i. step_q is a down-counter whose
  // terminal count ends each phase.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      a1_sh_q <= '0;
      a2_sh_q <= '0;
      prod_q  <= '0;
      step_q  <= '0;
`ifdef GPIOEMU_MULPOP_POPCNT_EN
      pop_q   <= '0;
`endif
    end else if (load_op) begin
      a1_sh_q <= PW'(a1_q);
      a2_sh_q <= a2_q;
      prod_q  <= '0;
      step_q  <= SW'(N - 1);
`ifdef GPIOEMU_MULPOP_POPCNT_EN
      pop_q   <= '0;
`endif
    end else if (mult_step) begin
      if (a2_sh_q[0]) prod_q <= prod_q + a1_sh_q;
      a1_sh_q <= a1_sh_q << 1;
      a2_sh_q <= a2_sh_q >> 1;
`ifdef GPIOEMU_MULPOP_POPCNT_EN
      // Reload for the ones-count sweep over all product bits.
      step_q  <= last_step ? SW'(PW - 1) : step_q - 1'b1;
`else
      step_q  <= step_q - 1'b1;
`endif
`ifdef GPIOEMU_MULPOP_POPCNT_EN
    end else if (pop_step) begin
      pop_q  <= pop_q + LW'(prod_q[step_q]);
      step_q <= step_q - 1'b1;
`endif
    end
  end

  // ---------------------------------------------------------------- status / counter
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      status_q <= ST_IDLE;
      cnt_q    <= '0;
    end else begin
      if (load_op)    status_q <= ST_BUSY;
      if (enter_done) status_q <= ST_DONE;
      if (done_pulse) cnt_q    <= cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- read path
  assign prod_ext = 64'(prod_q);

  // Result registers are masked while an operation is in flight so the CPU
  // never sees a partial product or partial count.
  always_comb begin
    rd_data = '0;
    if (saddress == ADDR_CS) begin
      rd_data = {30'b0, status_q};
    end else if (!busy) begin
      if (saddress == ADDR_WL) begin
        rd_data = prod_ext[31:0];
      end else if (saddress == ADDR_WH) begin
        rd_data = prod_ext[63:32];
      end else if (saddress == ADDR_L) begin
`ifdef GPIOEMU_MULPOP_POPCNT_EN
        rd_data = 32'(pop_q);
`else
        rd_data = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sdata_out_q <= '0;
    end else if (rd_en) begin
      sdata_out_q <= rd_data;
    end
  end

  // ---------------------------------------------------------------- gpio capture
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      gpio_in_s_q <= '0;
    end else if (latch_edge) begin
      gpio_in_s_q <= gpio_in;
    end
  end

  assign sdata_out      = sdata_out_q;
  assign gpio_out       = 32'(cnt_q);
  assign gpio_in_s_insp = gpio_in_s_q;

endmodule

// File: tb/tb_gpioemu_mulpop.sv
module tb_gpioemu_mulpop;

  localparam int N     = 24;
  localparam int CNT_W = 8;
  localparam logic [15:0] A_A1 = 16'h0370;
  localparam logic [15:0] A_A2 = 16'h0378;
  localparam logic [15:0] A_WH = 16'h0388;
  localparam logic [15:0] A_WL = 16'h0390;
  localparam logic [15:0] A_L  = 16'h0398;
  localparam logic [15:0] A_CS = 16'h03A0;
`ifdef GPIOEMU_MULPOP_POPCNT_EN
  localparam bit POP = 1'b1;
`else
  localparam bit POP = 1'b0;
`endif
  // Cycles from the start-detect edge to the first read that sees DONE.
  localparam int LAT = POP ? (1 + 3 * N) : (1 + N);
  localparam logic [31:0] OPMASK  = 32'h00FF_FFFF;
  localparam int unsigned CNT_MOD = 1 << CNT_W;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] saddress;
  logic        srd, swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;
  logic [31:0] gpio_in;
  logic        gpio_latch;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in_s_insp;

  gpioemu_mulpop #(
    .N(N), .CNT_W(CNT_W),
    .ADDR_A1(A_A1), .ADDR_A2(A_A2), .ADDR_WH(A_WH),
    .ADDR_WL(A_WL), .ADDR_L(A_L), .ADDR_CS(A_CS)
  ) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: operand registers and op counter as the bus has set them.
  logic [31:0] m_a1 = '0;
  logic [31:0] m_a2 = '0;
  int unsigned m_cnt = 0;

  typedef struct {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] wl;
    logic [31:0] wh;
    logic [31:0] l;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write access; s = cycle index of the edge that detected it.
  task automatic wr(input logic [15:0] addr, input logic [31:0] data, output int unsigned s);
    saddress = addr;
    sdata_in = data;
    swr = 1'b1;
    tick();
    s = cyc;
    swr = 1'b0;
    tick();
    if (addr == A_A1) m_a1 = data & OPMASK;
    if (addr == A_A2) m_a2 = data & OPMASK;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [31:0] d, output int unsigned r);
    saddress = addr;
    srd = 1'b1;
    tick();
    d = sdata_out;
    r = cyc;
    srd = 1'b0;
    tick();
  endtask

  // Start an operation on the current operands, poll status against the
  // latency rule, and check the op counter. p returns the expected product.
  task automatic run_op(input bit mid, input string tag, output logic [63:0] p);
    int unsigned s, r, dummy, polls;
    logic [31:0] d, exp_st;
    bit fin;
    wr(A_CS, 32'h1, s);
    p = 64'(m_a1) * 64'(m_a2);
    fin = 1'b0;
    polls = 0;
    while (!fin && polls < 120) begin
      rd(A_CS, d, r);
      exp_st = ((r - s) >= LAT) ? 32'd2 : 32'd1;
      check({tag, "_cs"}, d, exp_st);
      if (exp_st == 32'd2 || d == 32'd2) fin = 1'b1;
      polls++;
      if (mid && polls == 3) begin
        wr(A_CS, 32'h1, dummy);
        rd(A_WL, d, r);
        check({tag, "_busy_wl"}, d, 32'h0);
        rd(A_L, d, r);
        check({tag, "_busy_l"}, d, 32'h0);
        wr(A_A1, 32'h00AB_CDEF, dummy);
      end
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: status never reached 2 after %0d polls", tag, polls);
    end
    m_cnt = (m_cnt + 1) % CNT_MOD;
    check({tag, "_gpio"}, gpio_out, 32'(m_cnt));
  endtask

  task automatic check_result(input string tag, input logic [31:0] wl, input logic [31:0] wh,
                              input logic [31:0] l);
    logic [31:0] d;
    int unsigned r;
    rd(A_WL, d, r);
    check({tag, "_wl"}, d, wl);
    rd(A_WH, d, r);
    check({tag, "_wh"}, d, wh);
    rd(A_L, d, r);
    check({tag, "_l"}, d, POP ? l : 32'h0);
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1, "cycle budget exhausted");
  end

  initial begin
    logic [63:0] p;
    logic [31:0] d;
    int unsigned s, r;

    vecs[0] = '{32'd3,        32'd5,        32'h0000_000F, 32'h0000_0000, 32'd4};
    vecs[1] = '{32'h00FF_FFFF, 32'h00FF_FFFF, 32'hFE00_0001, 32'h0000_FFFF, 32'd24};
    vecs[2] = '{32'h0,        32'h0012_3456, 32'h0,        32'h0,         32'd0};
    vecs[3] = '{32'h00AB_CDEF, 32'h0,        32'h0,        32'h0,         32'd0};
    vecs[4] = '{32'hFF12_3456, 32'd1,        32'h0012_3456, 32'h0,        32'd9};
    vecs[5] = '{32'h0080_0000, 32'h0080_0000, 32'h0,       32'h0000_4000, 32'd1};
    vecs[6] = '{32'd1,        32'd1,        32'd1,         32'h0,         32'd1};
    vecs[7] = '{32'h0000_0FFF, 32'h0000_1001, 32'h00FF_FFFF, 32'h0,       32'd24};

    n_reset = 1'b0;
    saddress = '0; srd = 1'b0; swr = 1'b0; sdata_in = '0;
    gpio_in = '0; gpio_latch = 1'b0;
    repeat (3) tick();
    check("rst_sdata_out", sdata_out, 32'h0);
    check("rst_gpio_out", gpio_out, 32'h0);
    check("rst_insp", gpio_in_s_insp, 32'h0);
    n_reset = 1'b1;
    tick();
    rd(A_CS, d, r);
    check("rst_status", d, 32'h0);

    // gpio_in capture on the latch rising edge only.
    gpio_in = 32'hA5A5_1234;
    gpio_latch = 1'b1;
    tick();
    check("latch_capture", gpio_in_s_insp, 32'hA5A5_1234);
    gpio_in = 32'h0BAD_F00D;
    tick();
    check("latch_level_hold", gpio_in_s_insp, 32'hA5A5_1234);
    gpio_latch = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      wr(A_A1, vecs[i].a1, s);
      wr(A_A2, vecs[i].a2, s);
      run_op(1'b0, $sformatf("vec%0d", i), p);
      check_result($sformatf("vec%0d", i), vecs[i].wl, vecs[i].wh, vecs[i].l);
    end

    // Start and A1 write while busy: the running op is unaffected, the new
    // A1 applies to the following operation.
    wr(A_A1, 32'h0000_1234, s);
    wr(A_A2, 32'h0000_5678, s);
    run_op(1'b1, "busy", p);
    check_result("busy", p[31:0], p[63:32], 32'($countones(p)));
    run_op(1'b0, "after_busy", p);
    check_result("after_busy", p[31:0], p[63:32], 32'($countones(p)));

    for (int i = 0; i < 20; i++) begin
      wr(A_A1, $urandom, s);
      wr(A_A2, $urandom, s);
      repeat ($urandom_range(0, 3)) tick();
      run_op(1'b0, $sformatf("rnd%0d", i), p);
      check_result($sformatf("rnd%0d", i), p[31:0], p[63:32], 32'($countones(p)));
    end

    // Unmapped address reads zero.
    rd(A_CS, d, r);
    check("pre_unmapped_cs", d, 32'h2);
    rd(16'h03FF, d, r);
    check("unmapped_read", d, 32'h0);

    // Read and write rising together: write wins, sdata_out holds.
    rd(A_CS, d, r);
    check("pre_rdwr_cs", d, 32'h2);
    saddress = A_A1;
    sdata_in = 32'h00C0_FFEE;
    srd = 1'b1;
    swr = 1'b1;
    tick();
    srd = 1'b0;
    swr = 1'b0;
    m_a1 = 32'h00C0_FFEE;
    tick();
    check("rdwr_sdata_hold", sdata_out, 32'h2);
    wr(A_A2, 32'd2, s);
    run_op(1'b0, "rdwr", p);
    check_result("rdwr", 32'h0181_FFDC, 32'h0, 32'($countones(p)));

    // Reset during MULT step 10 aborts with everything cleared.
    wr(A_A1, 32'h55, s);
    wr(A_A2, 32'h00FF_FFFF, s);
    rd(A_CS, d, r);
    check("pre_abort_cs", d, 32'h2);
    wr(A_CS, 32'h1, s);
    while (cyc < s + 11) tick();
    n_reset = 1'b0;
    #1;
    check("abort_sdata_out", sdata_out, 32'h0);
    check("abort_gpio_out", gpio_out, 32'h0);
    check("abort_insp", gpio_in_s_insp, 32'h0);
    tick();
    n_reset = 1'b1;
    m_cnt = 0;
    m_a1 = '0;
    m_a2 = '0;
    tick();
    rd(A_CS, d, r);
    check("abort_status", d, 32'h0);
    repeat (LAT + 5) tick();
    check("abort_no_count", gpio_out, 32'h0);
    wr(A_A1, 32'd7, s);
    wr(A_A2, 32'd6, s);
    run_op(1'b0, "post_abort", p);
    check_result("post_abort", 32'd42, 32'h0, 32'd3);

    // 256 more operations: the counter wraps through zero and back.
    wr(A_A1, $urandom, s);
    wr(A_A2, $urandom, s);
    for (int i = 0; i < 256; i++) begin
      run_op(1'b0, "wrap", p);
      if (m_cnt == 0) begin
        check("wrap_zero", gpio_out, 32'h0);
      end
    end
    check("wrap_final", gpio_out, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
